// File: rtl/vga_sync_decoder.sv
// VGA sync receiver: recovers pixel position, active window and frame start
// from incoming hsync/vsync, tracks timing lock and flags timing errors.
module vga_sync_decoder #(
   parameter int width       = 640,
   parameter int pulse       = 96,
   parameter int front_porch = 16,
   parameter int back_porch  = 48,
   parameter int h_pol       = 0,
   parameter int v_width     = 480,
   parameter int v_pulse     = 2,
   parameter int v_front     = 10,
   parameter int v_back      = 33,
   parameter int v_pol       = 0,
   parameter int lock_lines  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hsync,
   input  logic       vsync,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active,
   output logic       frame_start,
   output logic       locked,
   output logic       line_err,
   output logic       frame_err
);

   localparam int h_total = pulse + back_porch + width + front_porch;
   localparam int v_total = v_pulse + v_back + v_width + v_front;

   localparam logic [9:0] h_last  = 10'(h_total - 1);
   localparam logic [9:0] h_end   = 10'(h_total);
   localparam logic [9:0] p_last  = 10'(pulse - 1);
   localparam logic [9:0] v_last  = 10'(v_total - 1);
   localparam logic [9:0] h_start = 10'(pulse + back_porch);
   localparam logic [9:0] h_stop  = 10'(pulse + back_porch + width - 1);
   localparam logic [9:0] v_start = 10'(v_pulse + v_back);
   localparam logic [9:0] v_stop  = 10'(v_pulse + v_back + v_width - 1);
   localparam logic [7:0] lock_need = 8'(lock_lines);
   localparam logic hs_on = (h_pol != 0);
   localparam logic vs_on = (v_pol != 0);

   typedef enum logic [1:0] {
      st_search,
      st_track,
      st_locked
   } state_t;

   state_t     state;
   logic       hs_q, hs_qq, vs_q, vs_qq;
   logic [9:0] h_cnt, v_cnt;
   logic       vs_pend, pulse_ok;
   logic [7:0] good, good_nxt;
   logic       hs_rise, hs_fall, vs_rise, vs_trig;
   logic       len_ok, line_good, timeout, pw_bad;
   logic       h_in, v_in;

   assign hs_rise   = (hs_q == hs_on) && (hs_qq != hs_on);
   assign hs_fall   = (hs_q != hs_on) && (hs_qq == hs_on);
   assign vs_rise   = (vs_q == vs_on) && (vs_qq != vs_on);
   assign vs_trig   = hs_rise && (vs_pend || vs_rise);
   assign len_ok    = (h_cnt == h_last);
   assign line_good = len_ok && pulse_ok;
   assign pw_bad    = hs_fall && (h_cnt != p_last);
   // Missing hsync: counter ran one past the nominal line end.
   assign timeout   = !hs_rise && (h_cnt == h_end);

   always_comb begin
      good_nxt = '0;
      if (line_good)
         good_nxt = (good >= lock_need) ? good : good + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hs_q      <= !hs_on;
         hs_qq     <= !hs_on;
         vs_q      <= !vs_on;
         vs_qq     <= !vs_on;
         h_cnt     <= '0;
         v_cnt     <= '0;
         vs_pend   <= 1'b0;
         pulse_ok  <= 1'b0;
         good      <= '0;
         state     <= st_search;
         line_err  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         hs_q      <= hsync;
         hs_qq     <= hs_q;
         vs_q      <= vsync;
         vs_qq     <= vs_q;
         line_err  <= 1'b0;
         frame_err <= 1'b0;

         if (hs_rise)
            h_cnt <= '0;
         else if (h_cnt != '1)
            h_cnt <= h_cnt + 10'd1;

         if (hs_rise)
            vs_pend <= 1'b0;
         else if (vs_rise)
            vs_pend <= 1'b1;

         if (hs_rise) begin
            if (vs_trig)
               v_cnt <= '0;
            else if (v_cnt != '1)
               v_cnt <= v_cnt + 10'd1;
         end

         if (hs_fall)
            pulse_ok <= (h_cnt == p_last);

         unique case (state)
            st_search: begin
               if (hs_rise) begin
                  state <= st_track;
                  good  <= '0;
               end
            end
            st_track: begin
               if (pw_bad)
                  line_err <= 1'b1;
               if (timeout) begin
                  line_err <= 1'b1;
                  good     <= '0;
               end
               if (hs_rise) begin
                  if (!len_ok)
                     line_err <= 1'b1;
                  good <= good_nxt;
                  if (vs_trig && good_nxt >= lock_need)
                     state <= st_locked;
               end
            end
            st_locked: begin
               // Drop lock the cycle after an error pulse.
               if (line_err || frame_err)
                  state <= st_search;
               else begin
                  if (pw_bad || timeout || (hs_rise && !len_ok))
                     line_err <= 1'b1;
                  if (vs_trig && v_cnt != v_last)
                     frame_err <= 1'b1;
               end
            end
            default: state <= st_search;
         endcase
      end
   end

   assign locked      = (state == st_locked);
   assign h_in        = (h_cnt >= h_start) && (h_cnt <= h_stop);
   assign v_in        = (v_cnt >= v_start) && (v_cnt <= v_stop);
   assign active      = locked && h_in && v_in;
   assign x           = active ? h_cnt - h_start : '0;
   assign y           = active ? v_cnt - v_start : '0;
   assign frame_start = locked && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a reduced 25x13 timing
// (16x6 active) so that many frames fit in a short run.
module tb_vga_sync_decoder;

   localparam bit HP      = 1'b0;
   localparam bit VP      = 1'b0;
   localparam int H_TOT   = 25;
   localparam int PULSE   = 4;
   localparam int H_START = 7;
   localparam int H_STOP  = 22;
   localparam int V_LINES = 13;
   localparam int V_PULSE = 2;
   localparam int V_START = 5;
   localparam int V_STOP  = 10;

   localparam int K_UP   = 0;
   localparam int K_FS   = 1;
   localparam int K_LERR = 2;
   localparam int K_FERR = 3;
   localparam int K_DN   = 4;
   localparam int K_PIX  = 5;
   localparam int K_XY   = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       hsync = ~HP;
   logic       vsync = ~VP;
   logic [9:0] x, y;
   logic       active, frame_start, locked, line_err, frame_err;

   vga_sync_decoder #(
      .width(16), .pulse(4), .front_porch(2), .back_porch(3), .h_pol(0),
      .v_width(6), .v_pulse(2), .v_front(2), .v_back(3), .v_pol(0),
      .lock_lines(4)
   ) dut (
      .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
      .x(x), .y(y), .active(active), .frame_start(frame_start),
      .locked(locked), .line_err(line_err), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;
      int cyc;
      int a;
      int b;
   } ev_t;

   ev_t expq [4096];
   int  wr = 0;
   int  rd = 0;
   int  vectors = 0;
   int  miscompares = 0;
   int  zreq = 0;
   int  zdone = 0;
   bit  done = 1'b0;
   bit  lk_prev = 1'b0;

   function automatic string kname(input int k);
      case (k)
         K_UP:   return "lock_up";
         K_FS:   return "frame_start";
         K_LERR: return "line_err";
         K_FERR: return "frame_err";
         K_DN:   return "lock_down";
         K_PIX:  return "pixel";
         default: return "xy_nonzero";
      endcase
   endfunction

   task automatic push(input int k, input int c, input int a, input int b);
      if (wr < 4096) begin
         expq[wr] = '{k, c, a, b};
         wr++;
      end
   endtask

   task automatic observe(input int k, input int a, input int b);
      ev_t e;
      vectors++;
      if (rd >= wr) begin
         miscompares++;
         $display("FAIL unexpected %s @%0d got a=%0d b=%0d, want no event",
                  kname(k), cyc, a, b);
      end else begin
         e = expq[rd];
         rd++;
         if (e.kind != k || e.cyc != cyc || e.a != a || e.b != b) begin
            miscompares++;
            $display("FAIL %s: got %s @%0d a=%0d b=%0d, want %s @%0d a=%0d b=%0d",
                     kname(e.kind), kname(k), cyc, a, b,
                     kname(e.kind), e.cyc, e.a, e.b);
         end
      end
   endtask

   always @(negedge clk) begin
      if (zreq != zdone) begin
         zdone = zreq;
         vectors++;
         if ({x, y, active, locked, frame_start, line_err, frame_err} != '0) begin
            miscompares++;
            $display("FAIL all_zero @%0d: got x=%0d y=%0d act=%b lk=%b fs=%b le=%b fe=%b, want all 0",
                     cyc, x, y, active, locked, frame_start, line_err, frame_err);
         end
      end
      if (locked && !lk_prev) observe(K_UP, 0, 0);
      if (frame_start)        observe(K_FS, 0, 0);
      if (line_err)           observe(K_LERR, 0, 0);
      if (frame_err)          observe(K_FERR, 0, 0);
      if (!locked && lk_prev) observe(K_DN, 0, 0);
      if (active)             observe(K_PIX, int'(x), int'(y));
      if (!active && (x != '0 || y != '0)) observe(K_XY, int'(x), int'(y));
      lk_prev = locked;
      if (done) begin
         while (rd < wr) begin
            vectors++;
            miscompares++;
            $display("FAIL missing %s: got nothing, want event @%0d a=%0d b=%0d",
                     kname(expq[rd].kind), expq[rd].cyc, expq[rd].a, expq[rd].b);
            rd++;
         end
         $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
         $finish;
      end
   end

   task automatic drive(input bit hs, input bit vs);
      hsync = hs ? HP : ~HP;
      vsync = vs ? VP : ~VP;
      @(posedge clk);
      #1;
   endtask

   // lk: locked while this line's outputs appear; flags add expected errors.
   task automatic send_line(input int len, input int pw, input bit vs,
                            input bit lk, input int row, input bit up,
                            input bit lerr, input bit ferr, input bit pwerr);
      int s;
      s = cyc;
      if (up) push(K_UP, s + 2, 0, 0);
      if (lk && row == 0) push(K_FS, s + 2, 0, 0);
      if (lerr) push(K_LERR, s + 2, 0, 0);
      if (ferr) push(K_FERR, s + 2, 0, 0);
      if (lerr || ferr) push(K_DN, s + 3, 0, 0);
      if (pwerr) begin
         push(K_LERR, s + pw + 2, 0, 0);
         push(K_DN, s + pw + 3, 0, 0);
      end
      if (lk && !lerr && !ferr && !pwerr && row >= V_START && row <= V_STOP)
         for (int h = H_START; h <= H_STOP && h < len; h++)
            push(K_PIX, s + 2 + h, h - H_START, row - V_START);
      for (int i = 0; i < len; i++)
         drive(i < pw, vs);
   endtask

   task automatic send_frame(input int n, input bit lk, input bit up, input bit ferr);
      for (int r = 0; r < n; r++)
         send_line(H_TOT, PULSE, r < V_PULSE, lk && !(ferr && r > 0), r,
                   up && r == 0, 1'b0, ferr && r == 0, 1'b0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no end of run, want summary");
      $fatal(1);
   end

   initial begin
      int s;
      @(posedge clk);
      #1;
      zreq++;
      drive(0, 0);
      drive(0, 0);
      rst = 1'b0;
      drive(0, 0);
      zreq++;
      repeat (2000) drive(0, 0);
      zreq++;

      // acquire: lock at the second vsync
      send_frame(V_LINES, 0, 0, 0);
      send_frame(V_LINES, 1, 1, 0);
      send_frame(V_LINES, 1, 0, 0);

      // 26-clock line in row 6, error at row 7 start, relock next frame
      for (int r = 0; r < V_LINES; r++)
         send_line(r == 6 ? H_TOT + 1 : H_TOT, PULSE, r < V_PULSE, r < 7, r,
                   1'b0, r == 7, 1'b0, 1'b0);

      // short hsync pulse in row 3
      for (int r = 0; r < V_LINES; r++)
         send_line(H_TOT, r == 3 ? PULSE - 1 : PULSE, r < V_PULSE, r <= 3, r,
                   r == 0, 1'b0, 1'b0, r == 3);
      send_frame(V_LINES, 1, 1, 0);

      // hsync stops in row 5
      for (int r = 0; r < 5; r++)
         send_line(H_TOT, PULSE, r < V_PULSE, 1'b1, r, 1'b0, 1'b0, 1'b0, 1'b0);
      s = cyc;
      for (int h = H_START; h <= H_STOP; h++)
         push(K_PIX, s + 2 + h, h - H_START, 0);
      push(K_LERR, s + 3 + H_TOT, 0, 0);
      push(K_DN, s + 4 + H_TOT, 0, 0);
      for (int i = 0; i < 60; i++)
         drive(i < PULSE, 0);

      // short frame (12 lines) while locked
      send_frame(V_LINES, 0, 0, 0);
      send_frame(V_LINES, 1, 1, 0);
      send_frame(V_LINES - 1, 1, 0, 0);
      send_frame(V_LINES, 1, 0, 1);

      // reset in the middle of an active line
      for (int r = 0; r < 7; r++)
         send_line(H_TOT, PULSE, r < V_PULSE, 1'b1, r, r == 0, 1'b0, 1'b0, 1'b0);
      s = cyc;
      for (int h = H_START; h <= 12; h++)
         push(K_PIX, s + 2 + h, h - H_START, 2);
      push(K_DN, s + 15, 0, 0);
      for (int i = 0; i < 14; i++)
         drive(i < PULSE, 0);
      rst = 1'b1;
      drive(0, 0);
      zreq++;
      drive(0, 0);
      rst = 1'b0;

      send_frame(V_LINES, 0, 0, 0);
      send_frame(V_LINES, 1, 1, 0);

      @(negedge clk);
      #1;
      done = 1'b1;
   end

endmodule
